cnn_layer_sequencer: RTL and testbench
======================================

// Module: cnn_layer_sequencer
// PURPOSE
//  Frame-level scheduler for the CNN pipeline. Runs the conv/pool layer iterators in order
//  (layer 0 .. N_LAYERS-1) once per captured camera frame: waits for weight/bias preload,
//  pulses each layer's start, waits for its completion, flips the ping-pong feature buffer,
//  then reports the frame result. Sits between the frame-capture logic and the iterators.
// PARAMETERS
//  N_LAYERS   3      number of sequenced layers (>=1)
//  TIMEOUT    4096   clk_en cycles allowed per layer before abort (>=2)
//  DROP_W     8      width of saturating dropped-frame counter
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         async reset, active low
//  clk_en       in   1         state advances only when 1; outputs hold otherwise
//  frame_valid  in   1         1-cycle pulse: new frame stored in input buffer
//  cfg_ready    in   N_LAYERS  per layer: filter and bias preload complete (level)
//  layer_done   in   N_LAYERS  per layer: iterator finished (1-cycle pulse)
//  layer_go     out  N_LAYERS  one-hot 1-cycle start pulse to current layer
//  buf_sel      out  1         ping-pong select: layer reads bank buf_sel, writes ~buf_sel
//  busy         out  1         frame in progress
//  result_valid out  1         1-cycle pulse: last layer finished, result in bank buf_sel
//  err_timeout  out  1         sticky: a layer exceeded TIMEOUT; cleared only by reset
//  drop_cnt     out  DROP_W    frames rejected while busy, saturating
// BEHAVIOUR
//  - Reset values: layer_go=0, buf_sel=0, busy=0, result_valid=0, err_timeout=0, drop_cnt=0,
//    state=IDLE, layer index=0, watchdog=0.
//  - All registers update only on posedge clk with clk_en=1; inputs sampled only then.
//  - FSM: IDLE -> (frame_valid) WAIT_CFG; WAIT_CFG -> (cfg_ready[idx]) LAUNCH;
//    LAUNCH (1 cycle, layer_go[idx]=1) -> RUN; RUN -> (layer_done[idx]) ADVANCE;
//    ADVANCE: buf_sel toggles; idx==N_LAYERS-1 -> DONE, else idx+1 -> WAIT_CFG;
//    DONE (1 cycle, result_valid=1, idx<=0, buf_sel<=0) -> IDLE.
//  - busy=1 in every state except IDLE; registered (asserts the cycle after frame_valid).
//  - Latency: frame_valid to layer_go[0] = 2 clk_en cycles when cfg_ready[0] already high.
//  - frame_valid while busy: frame dropped, drop_cnt+1 (holds at 2^DROP_W-1); not queued.
//    frame_valid in same cycle as DONE also counts as drop.
//  - layer_done on index != idx, or outside RUN: ignored (no state change).
//  - layer_done[idx] in LAUNCH cycle: ignored; iterator cannot finish in 1 cycle.
//  - Watchdog: clears on LAUNCH, increments each clk_en cycle in RUN; reaching TIMEOUT sets
//    err_timeout, forces idx=0, buf_sel=0, state=IDLE; no result_valid for that frame.
//    layer_done and timeout in same cycle: layer_done wins.
//  - Watchdog does not run in WAIT_CFG (preload time unbounded).
//  - Async reset mid-frame returns to reset values immediately; no pulses on release.
//  - Widths: idx $clog2(N_LAYERS+1) bits; watchdog $clog2(TIMEOUT+1) bits.
// STRUCTURE
//  - Package cnn_pkg: typedef enum logic[2:0] seq_state_t {IDLE,WAIT_CFG,LAUNCH,RUN,
//    ADVANCE,DONE}; shared width helpers used by iterators and sequencer.
//  - One sub-module: cnn_watchdog (clear, enable, count, expired flag), reusable elsewhere.
//  - FSM, index/bank registers and drop counter live in the top module.
// TESTING
//  - N_LAYERS=3, cfg_ready=3'b111, frame_valid pulse, each done 10 cycles after go ->
//    go pulses 001,010,100 in order; buf_sel 0->1->0->1 then 0; one result_valid; busy low after.
//  - cfg_ready[1]=0 for 50 cycles -> layer_go[1] delayed until cfg_ready[1] rises, then 2 cycles.
//  - 5 frame_valid pulses while busy -> drop_cnt=5; DROP_W=2 with 5 pulses -> drop_cnt=3.
//  - TIMEOUT=16, layer 1 never done -> err_timeout at 16th RUN cycle, IDLE, no result_valid;
//    next frame runs normally with err_timeout still 1.
//  - clk_en toggling 1/0 -> sequence identical to first test with cycle counts doubled.
//  - Stray layer_done[2] during layer 0 RUN, and rst_n pulse mid-layer 1 -> ignored / all reset values.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the CNN pipeline control blocks.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CFG,
    LAUNCH,
    RUN,
    ADVANCE,
    DONE
  } seq_state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cnn_watchdog.sv
// Up-counting watchdog: cleared on demand, counts enabled cycles, flags the
// cycle on which the count would reach TIMEOUT.
module cnn_watchdog
  import cnn_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clk_en) begin
      if (clear) begin
        count <= '0;
      end else if (enable && count != CW'(TIMEOUT)) begin
        count <= count + CW'(1);
      end
    end
  end

  // Fires on the TIMEOUT-th enabled cycle since the last clear.
  assign expired = enable && (count >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame-level scheduler: walks the layer iterators in order once per frame,
// flipping the ping-pong feature bank after each layer.
//
//  state    | meaning
//  IDLE     | waiting for a captured frame
//  WAIT_CFG | waiting for preload of layer idx (unbounded)
//  LAUNCH   | layer_go[idx] pulse, watchdog cleared
//  RUN      | waiting for layer_done[idx], watchdog counting
//  ADVANCE  | flip bank, pick next layer or finish
//  DONE     | result_valid pulse, index/bank rewound
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int N_LAYERS = 3,
  parameter int TIMEOUT  = 4096,
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                frame_valid,
  input  logic [N_LAYERS-1:0] cfg_ready,
  input  logic [N_LAYERS-1:0] layer_done,
  output logic [N_LAYERS-1:0] layer_go,
  output logic                buf_sel,
  output logic                busy,
  output logic                result_valid,
  output logic                err_timeout,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int IDX_W = cnt_width(N_LAYERS);

  seq_state_t          state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                buf_sel_nxt, err_nxt;
  logic [N_LAYERS-1:0] cur;
  logic                cfg_hit, done_hit;
  logic                wd_clear, wd_en, wd_expired;

  assign cur      = N_LAYERS'(1) << idx;
  assign cfg_hit  = |(cfg_ready & cur);
  assign done_hit = |(layer_done & cur);

  cnn_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      buf_sel     <= 1'b0;
      err_timeout <= 1'b0;
    end else if (clk_en) begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      buf_sel     <= buf_sel_nxt;
      err_timeout <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    buf_sel_nxt = buf_sel;
    err_nxt     = err_timeout;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_valid) state_nxt = WAIT_CFG;
      end
      WAIT_CFG: begin
        if (cfg_hit) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        wd_clear  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        wd_en = 1'b1;
        // A completion arriving on the expiry cycle still counts as success.
        if (done_hit) begin
          state_nxt = ADVANCE;
        end else if (wd_expired) begin
          state_nxt   = IDLE;
          idx_nxt     = '0;
          buf_sel_nxt = 1'b0;
          err_nxt     = 1'b1;
        end
      end
      ADVANCE: begin
        buf_sel_nxt = ~buf_sel;
        if (idx == IDX_W'(N_LAYERS - 1)) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = WAIT_CFG;
        end
      end
      DONE: begin
        idx_nxt     = '0;
        buf_sel_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign layer_go     = (state == LAUNCH) ? cur : '0;
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

  // Frames arriving while a frame is in flight (DONE included) are lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (clk_en && frame_valid && state != IDLE && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: per-frame timelines are derived
// arithmetically from layer ready/done delays and compared every tick.
module tb_cnn_layer_sequencer;

  localparam int NL = 3;
  localparam int TO = 16;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          frame_valid = 1'b0;
  logic [NL-1:0] cfg_ready = '0;
  logic [NL-1:0] layer_done = '0;
  logic [NL-1:0] layer_go;
  logic          buf_sel, busy, result_valid, err_timeout;
  logic [DW-1:0] drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit slow = 1'b0;
  bit stray_en = 1'b0;

  logic [NL-1:0] exp_go;
  logic          exp_buf, exp_busy, exp_rv, exp_err;
  int            exp_drop;
  int            fr_rdy[NL];
  int            fr_dl[NL];

  cnn_layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(TO), .DROP_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .frame_valid  (frame_valid),
    .cfg_ready    (cfg_ready),
    .layer_done   (layer_done),
    .layer_go     (layer_go),
    .buf_sel      (buf_sel),
    .busy         (busy),
    .result_valid (result_valid),
    .err_timeout  (err_timeout),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string ph);
    check({ph, ":layer_go"}, 32'(layer_go), 32'(exp_go));
    check({ph, ":buf_sel"}, 32'(buf_sel), 32'(exp_buf));
    check({ph, ":busy"}, 32'(busy), 32'(exp_busy));
    check({ph, ":result_valid"}, 32'(result_valid), 32'(exp_rv));
    check({ph, ":err_timeout"}, 32'(err_timeout), 32'(exp_err));
    check({ph, ":drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic clear_exp();
    exp_go = '0; exp_buf = 1'b0; exp_busy = 1'b0; exp_rv = 1'b0;
    exp_err = 1'b0; exp_drop = 0;
  endtask

  // One enabled tick; in slow mode a disabled cycle with junk inputs comes first.
  task automatic step(input logic fv, input logic [NL-1:0] rdy, input logic [NL-1:0] dn);
    if (slow) begin
      clk_en = 1'b0;
      frame_valid = 1'($urandom);
      cfg_ready = NL'($urandom);
      layer_done = NL'($urandom);
      @(posedge clk); #1;
      check_outs("hold");
    end
    clk_en = 1'b1;
    frame_valid = fv;
    cfg_ready = rdy;
    layer_done = dn;
    @(posedge clk); #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '1, '0);
      check_outs("idle");
    end
  endtask

  // Tick n = n-th enabled edge after frame_valid is presented (n=1 samples it).
  // Layer k launches once WAIT_CFG has been entered and cfg_ready[k] is sampled high;
  // layer_done arrives on the fr_dl[k]-th RUN cycle (0 = never, watchdog fires).
  task automatic run_frame(input int n_drops, input int stop_at);
    int go[NL], adv[NL], wend[NL];
    int w, last, e, f, fin, tg, dropped, p;
    bit mark[];
    logic fv;
    logic [NL-1:0] rdy, dn;
    w = 1; last = -1; e = 0;
    for (int k = 0; k < NL; k++) begin
      go[k] = (w + 1 > fr_rdy[k]) ? w + 1 : fr_rdy[k];
      last = k;
      if (fr_dl[k] == 0) begin
        e = go[k] + TO + 1;
        wend[k] = e;
        break;
      end
      adv[k] = go[k] + 1 + fr_dl[k];
      wend[k] = adv[k];
      w = adv[k] + 1;
    end
    f = adv[NL-1] + 1;
    fin = (e == 0) ? f + 1 : e;
    mark = new[fin + 3];
    dropped = 0;
    if (n_drops > 0) begin
      mark[fin] = 1'b1;
      dropped = 1;
    end
    while (dropped < n_drops && dropped < fin - 1) begin
      p = $urandom_range(fin, 2);
      if (!mark[p]) begin
        mark[p] = 1'b1;
        dropped++;
      end
    end
    for (int n = 1; n <= fin + 2; n++) begin
      fv = (n == 1) || (n <= fin && mark[n]);
      for (int k = 0; k < NL; k++) begin
        rdy[k] = (n >= fr_rdy[k]);
        dn[k] = 1'b0;
        if (k <= last && fr_dl[k] != 0 && n == adv[k]) dn[k] = 1'b1;
        else if (stray_en && $urandom_range(7, 0) == 0 &&
                 !(k <= last && n >= go[k] + 2 && n <= wend[k])) dn[k] = 1'b1;
      end
      step(fv, rdy, dn);
      exp_go = '0;
      tg = 0;
      for (int k = 0; k <= last; k++) begin
        if (n == go[k]) exp_go[k] = 1'b1;
        if (fr_dl[k] != 0 && n >= adv[k] + 1) tg++;
      end
      exp_busy = (n < fin);
      exp_rv = (e == 0 && n == f);
      exp_buf = (n < fin) ? tg[0] : 1'b0;
      if (e != 0 && n >= e) exp_err = 1'b1;
      if (fv && n >= 2 && n <= fin && exp_drop < (1 << DW) - 1) exp_drop++;
      check_outs("frame");
      if (n == stop_at) break;
    end
  endtask

  initial begin
    clear_exp();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    rst_n = 1'b1;
    idle_ticks(3);

    fr_rdy = '{0, 0, 0}; fr_dl = '{10, 10, 10};
    run_frame(0, 0);

    fr_rdy = '{0, 60, 0};
    run_frame(0, 0);

    fr_rdy = '{0, 0, 0};
    run_frame(5, 0);
    check("drop_five", 32'(drop_cnt), 32'd5);
    run_frame(5, 0);
    check("drop_saturate", 32'(drop_cnt), 32'd7);

    fr_dl = '{TO, 1, TO};
    run_frame(0, 0);

    fr_dl = '{10, 0, 10};
    run_frame(1, 0);
    check("err_set", 32'(err_timeout), 32'd1);
    fr_dl = '{10, 10, 10};
    run_frame(0, 0);

    slow = 1'b1;
    run_frame(0, 0);

    stray_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      slow = i[0];
      for (int k = 0; k < NL; k++) begin
        fr_rdy[k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(80, 0)) : 0;
        fr_dl[k] = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(TO, 1));
      end
      run_frame(int'($urandom_range(3, 0)), 0);
    end

    slow = 1'b0; stray_en = 1'b0;
    fr_rdy = '{0, 0, 0}; fr_dl = '{5, 40, 5};
    run_frame(0, 20);
    frame_valid = 1'b0;
    layer_done = '0;
    #2 rst_n = 1'b0;
    #1;
    clear_exp();
    check_outs("async_rst");
    #3 rst_n = 1'b1;
    idle_ticks(5);
    fr_dl = '{10, 10, 10};
    run_frame(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
